data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Multi-cycle data-memory responder: the memory-side end of the pipelined CPU's
//  MEM-stage load/store interface. It replaces the single-cycle magic DataMemory
//  when stalls are modelled. It accepts one request at a time, waits a fixed
//  LATENCY, then returns read data or a write acknowledge with a valid/ready
//  handshake. The CPU's hazard unit stalls MEM while req_ready or resp_valid is
//  outstanding.
// PARAMETERS
//  DEPTH_WORDS  16384  number of 32-bit words in the array (power of 2)
//  LATENCY      4      cycles from request acceptance to resp_valid (>=1)
// PORTS
//  clk         in   1   clock; all state changes on the rising edge
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   CPU presents a request
//  req_ready   out  1   responder can accept a request this cycle
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; bits [1:0] are ignored
//  req_wdata   in   32  store data
//  resp_valid  out  1   response available
//  resp_ready  in   1   CPU consumes the response
//  resp_rdata  out  32  load data; 0 for store acknowledges
//  txn_count   out  32  number of completed (handshaken) responses
// BEHAVIOUR
//  - Reset (any cycle, including mid-transaction): state=IDLE, req_ready=1,
//    resp_valid=0, resp_rdata=0, txn_count=0, latency counter=0.
//    A pending store is dropped and never committed. The array is NOT cleared.
//  - Index = req_addr[log2(DEPTH_WORDS)+1:2]. Out-of-range addresses wrap modulo
//    DEPTH_WORDS. Word access only.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready=1 only in IDLE. All outputs
//    are registered.
//    IDLE: on req_valid&&req_ready, latch write/index/wdata.
//      LATENCY==1: go to RESP.
//      Otherwise: cnt<=LATENCY-1 and go to WAIT.
//    WAIT: cnt decrements each cycle. On the edge where cnt==1, go to RESP.
//    Entering RESP: resp_valid<=1.
//      Load: resp_rdata<=mem[index], read at that edge.
//      Store: mem[index]<=wdata committed at that same edge; resp_rdata<=0.
//    RESP: hold resp_valid and resp_rdata stable until resp_ready is sampled 1.
//      On that edge: resp_valid<=0, resp_rdata<=0, txn_count+=1 (wraps at
//      2^32), go to IDLE.
//  - Latency: resp_valid is first high exactly LATENCY cycles after the
//    acceptance cycle. Minimum period between accepts is LATENCY+1 cycles.
//    There is no same-cycle response-to-request overlap.
//  - req_* inputs are ignored outside IDLE. The payload is captured only at
//    acceptance, so later changes to the inputs have no effect.
//  - resp_ready while resp_valid=0 has no effect.
//  - A load after a store to the same word returns the stored value, because
//    the store commits before its acknowledge is visible.
// TESTING
//  1. Reset, LATENCY=4: store 0xDEADBEEF @0x10, then load @0x10 -> resp_valid
//     high 4 cycles after each accept; load rdata=0xDEADBEEF; txn_count=2.
//  2. Backpressure: hold resp_ready=0 for 5 cycles on a load -> resp_valid and
//     rdata stable, req_ready=0 throughout; txn_count increments only on the
//     handshake.
//  3. Wrap: store 0x1234 @ (DEPTH_WORDS*4 + 0x8), load @0x8 -> rdata=0x1234.
//     Load @0x9 -> rdata=0x1234 (bits [1:0] ignored).
//  4. Reset mid-WAIT of a store of 0xAAAA @0x20 (old value 0x5555) -> after
//     reset, load @0x20 returns 0x5555; all outputs at reset values.
//  5. LATENCY=1, back-to-back requests with resp_ready tied 1 -> accepts every
//     2 cycles; resp_valid 1 cycle after each accept.
//  6. Inputs changed during WAIT (addr, wdata, write toggled) -> response
//     reflects the payload latched at acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Accepts one word load/store at a time, waits LATENCY cycles, then returns
// read data or a store acknowledge over a valid/ready handshake.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [31:0] txn_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [31:0]        txn_count_q, txn_count_d;

  logic               commit_c;
  logic               commit_write_c;
  logic [IDX_W-1:0]   commit_idx_c;
  logic [31:0]        commit_wdata_c;
  logic               mem_we_c;

  logic [31:0]        mem_q [DEPTH_WORDS];

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr_c;
  assign unused_addr_c = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

  // Next-state, payload capture and response generation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    write_d        = write_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    txn_count_d    = txn_count_q;
    commit_c       = 1'b0;
    commit_write_c = write_q;
    commit_idx_c   = idx_q;
    commit_wdata_c = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          idx_d       = req_addr[IDX_W+1:2];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            // Single-cycle latency commits straight from the request bus.
            commit_c       = 1'b1;
            commit_write_c = req_write;
            commit_idx_c   = req_addr[IDX_W+1:2];
            commit_wdata_c = req_wdata;
            state_d        = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          commit_c = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          txn_count_d  = txn_count_q + 32'd1;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering RESP: loads sample the array, stores acknowledge with zero.
    if (commit_c) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = commit_write_c ? 32'h0 : mem_q[commit_idx_c];
    end
    mem_we_c = commit_c && commit_write_c;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      txn_count_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      txn_count_q  <= txn_count_d;
    end
  end

  // Storage array; not cleared by reset, and a store racing reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem_q[commit_idx_c] <= commit_wdata_c;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign txn_count  = txn_count_q;

endmodule
